// File: rtl/if_id_stage_reg_if.sv
// IF/ID handshake bundle.
//   Fetch side : in_valid, in_ready, in_instr, in_pc4, flush
//   Decode side: out_valid, out_ready, out_instr, out_pc4
// modport slave  - the IF/ID stage register itself
// modport master - the environment (fetch + decode) driving it
interface if_id_stage_reg_if #(
  parameter int unsigned PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc4;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc4;

  modport slave (
    input  in_valid, in_instr, in_pc4, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc4
  );

  modport master (
    output in_valid, in_instr, in_pc4, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc4
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline boundary register for the MIPS core.
// Holds the fetched instruction and PC+4 in a 2-entry skid buffer (main + overflow
// slot) so that in_ready can come straight from a flop while still sustaining one
// instruction per cycle. Presents the held word and its decoded fields to decode.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            handshake bundle (fetch in_*, decode out_*, flush)
//   opcode..jaddr  field slices of the gated out_instr
module if_id_stage_reg #(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  if_id_stage_reg_if.slave  bus,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm_16,
  output logic [25:0]       jaddr
);

  logic            main_valid_q, main_valid_d;
  logic [31:0]     main_instr_q, main_instr_d;
  logic [PC_W-1:0] main_pc4_q,   main_pc4_d;
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] skid_pc4_q,   skid_pc4_d;
  logic            in_ready_q;

  logic accept;
  logic drain;

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = main_valid_q & bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc4_d   = main_pc4_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    if (bus.flush) begin
      // Data regs keep stale contents; output gating hides them.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so no accept can coincide here.
        main_instr_d = skid_instr_q;
        main_pc4_d   = skid_pc4_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_instr_d = bus.in_instr;
        main_pc4_d   = bus.in_pc4;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_instr_d = bus.in_instr;
        main_pc4_d   = bus.in_pc4;
      end
    end else if (accept) begin
      // Main is stalled: park the new word behind it to keep order.
      skid_valid_d = 1'b1;
      skid_instr_d = bus.in_instr;
      skid_pc4_d   = bus.in_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc4_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc4_q   <= main_pc4_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_instr = main_valid_q ? main_instr_q : NOP_INSTR;
  assign bus.out_pc4   = main_valid_q ? main_pc4_q : '0;

  assign opcode = bus.out_instr[31:26];
  assign rs     = bus.out_instr[25:21];
  assign rt     = bus.out_instr[20:16];
  assign rd     = bus.out_instr[15:11];
  assign shamt  = bus.out_instr[10:6];
  assign funct  = bus.out_instr[5:0];
  assign imm_16 = bus.out_instr[15:0];
  assign jaddr  = bus.out_instr[25:0];

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg. Inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
module tb_if_id_stage_reg;

  logic clk;
  logic rst_n;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm_16;
  logic [25:0] jaddr;

  int unsigned n_cmp;
  int unsigned n_bad;

  if_id_stage_reg_if #(.PC_W(32)) bus ();

  if_id_stage_reg #(
    .PC_W      (32),
    .NOP_INSTR (32'h0000_0000)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm_16 (imm_16),
    .jaddr  (jaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc4   = pc4;
  endtask

  logic [31:0] words [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    words[0] = 32'h2009_0001;
    words[1] = 32'h012A_5820;
    words[2] = 32'h8D0C_0010;
    words[3] = 32'h1000_FFFF;

    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);

    // Reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_pc4", bus.out_pc4, 0);
    check("rst_opcode", opcode, 0);

    // 1: single addi, one-cycle latency
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    offer(1'b1, 32'h2008_0005, 32'd4);
    @(negedge clk);
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_rt", rt, 8);
    check("t1_imm", imm_16, 16'h0005);
    check("t1_opcode", opcode, 6'h08);
    check("t1_pc4", bus.out_pc4, 4);
    offer(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t1_drained", bus.out_valid, 0);

    // 2: back-to-back stream
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, words[i], 32'(100 + 4 * i));
      @(negedge clk);
      check($sformatf("t2_instr%0d", i), bus.out_instr, words[i]);
      check($sformatf("t2_pc4_%0d", i), bus.out_pc4, 100 + 4 * i);
      check($sformatf("t2_in_ready%0d", i), bus.in_ready, 1);
    end
    offer(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t2_empty", bus.out_valid, 0);

    // 3: stall while A,B,C offered
    bus.out_ready = 1'b0;
    offer(1'b1, 32'hAAAA_0001, 32'h10);
    @(negedge clk);
    check("t3_a_main", bus.out_instr, 32'hAAAA_0001);
    check("t3_rdy_after_a", bus.in_ready, 1);
    offer(1'b1, 32'hBBBB_0002, 32'h14);
    @(negedge clk);
    check("t3_a_held1", bus.out_instr, 32'hAAAA_0001);
    check("t3_rdy_after_b", bus.in_ready, 0);
    offer(1'b1, 32'hCCCC_0003, 32'h18);
    @(negedge clk);
    check("t3_a_held2", bus.out_instr, 32'hAAAA_0001);
    check("t3_a_valid", bus.out_valid, 1);
    check("t3_rdy_c_held", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_b_out", bus.out_instr, 32'hBBBB_0002);
    check("t3_b_pc4", bus.out_pc4, 32'h14);
    check("t3_rdy_rise", bus.in_ready, 1);
    @(negedge clk);
    check("t3_c_out", bus.out_instr, 32'hCCCC_0003);
    check("t3_c_pc4", bus.out_pc4, 32'h18);
    offer(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t3_no_dup", bus.out_valid, 0);

    // 4: flush with main+skid full and a word offered
    bus.out_ready = 1'b0;
    offer(1'b1, 32'hDDDD_0004, 32'h20);
    @(negedge clk);
    offer(1'b1, 32'hEEEE_0005, 32'h24);
    @(negedge clk);
    check("t4_full_rdy", bus.in_ready, 0);
    offer(1'b1, 32'hFFFF_0006, 32'h28);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_out_valid", bus.out_valid, 0);
    check("t4_out_instr", bus.out_instr, 0);
    check("t4_out_pc4", bus.out_pc4, 0);
    check("t4_in_ready", bus.in_ready, 1);
    bus.flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t4_dropped", bus.out_valid, 0);

    // 5: async reset mid-cycle with entries held, then 6: j decode
    bus.out_ready = 1'b0;
    offer(1'b1, 32'h1111_0007, 32'h30);
    @(negedge clk);
    offer(1'b1, 32'h2222_0008, 32'h34);
    @(negedge clk);
    check("t5_pre_valid", bus.out_valid, 1);
    offer(1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", bus.out_valid, 0);
    check("t5_async_rdy", bus.in_ready, 1);
    check("t5_async_opcode", opcode, 0);
    check("t5_async_instr", bus.out_instr, 0);
    #1 rst_n = 1'b1;
    offer(1'b1, 32'h0800_1234, 32'h40);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t6_valid", bus.out_valid, 1);
    check("t6_opcode", opcode, 6'h02);
    check("t6_jaddr", jaddr, 26'h000_1234);
    check("t6_imm", imm_16, 16'h1234);
    check("t6_funct", funct, 6'h34);
    offer(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t6_drained", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
